// File: rtl/reg_scoreboard.sv
// Register-file scoreboard: tracks in-flight destination writes and stalls issue on RAW/WAW/full.
// Optional macro REG_SCOREBOARD_WB_BYPASS_EN lets a same-cycle writeback clear hazards combinationally.
module reg_scoreboard #(
  parameter int NREGS   = 32,
  parameter int AW      = 5,
  parameter int MAX_OUT = 8,
  parameter int CW      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rs1,
  input  logic [AW-1:0]    iss_rs2,
  input  logic             iss_use_rs1,
  input  logic             iss_use_rs2,
  input  logic [AW-1:0]    iss_rd,
  input  logic             iss_rd_wr,
  output logic             iss_ready,
  input  logic             wb_valid,
  input  logic [AW-1:0]    wb_rd,
  output logic [NREGS-1:0] pending,
  output logic [CW-1:0]    outstanding,
  output logic             idle,
  output logic             wb_spurious,
  output logic [31:0]      stall_cycles
);

  logic [NREGS-1:0] r_pending;
  logic [CW-1:0]    r_outstanding;
  logic             r_wb_spurious;
  logic [31:0]      r_stall_cycles;

  logic             w_wb_hit;
  logic             w_rd_live;
  logic [NREGS-1:0] w_pend_view;
  logic [CW-1:0]    w_occupancy;
  logic             w_raw;
  logic             w_waw;
  logic             w_full;
  logic             w_clr;
  logic             w_set;
  logic             w_stall;
  logic [NREGS-1:0] w_pending_nxt;
  logic [CW-1:0]    w_outstanding_nxt;

  assign w_wb_hit  = wb_valid & (wb_rd != '0);
  assign w_rd_live = iss_rd_wr & (iss_rd != '0);
  assign w_clr     = w_wb_hit & r_pending[wb_rd];

`ifdef REG_SCOREBOARD_WB_BYPASS_EN
  // A register being written back this cycle no longer blocks a reader or writer.
  assign w_pend_view = r_pending & ~(w_wb_hit ? (NREGS'(1) << wb_rd) : '0);
  assign w_occupancy = r_outstanding - CW'(w_clr);
`else
  assign w_pend_view = r_pending;
  assign w_occupancy = r_outstanding;
`endif

  assign w_raw  = (iss_use_rs1 & w_pend_view[iss_rs1]) | (iss_use_rs2 & w_pend_view[iss_rs2]);
  assign w_waw  = w_rd_live & w_pend_view[iss_rd];
  assign w_full = w_rd_live & (w_occupancy == CW'(MAX_OUT));

  assign iss_ready = ~flush & ~w_raw & ~w_waw & ~w_full;
  assign w_set     = iss_valid & iss_ready & w_rd_live;
  assign w_stall   = iss_valid & ~iss_ready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_clr) w_pending_nxt[wb_rd] = 1'b0;
    // The set is applied after the clear so a same-register clear+set leaves the bit set.
    if (w_set) w_pending_nxt[iss_rd] = 1'b1;
    w_pending_nxt[0] = 1'b0;
    w_outstanding_nxt = r_outstanding + CW'(w_set) - CW'(w_clr);
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending      <= '0;
      r_outstanding  <= '0;
      r_wb_spurious  <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      if (flush) begin
        r_pending     <= '0;
        r_outstanding <= '0;
      end else begin
        r_pending     <= w_pending_nxt;
        r_outstanding <= w_outstanding_nxt;
      end
      r_wb_spurious <= w_wb_hit & ~r_pending[wb_rd];
      if (w_stall && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign pending      = r_pending;
  assign outstanding  = r_outstanding;
  assign idle         = (r_outstanding == '0);
  assign wb_spurious  = r_wb_spurious;
  assign stall_cycles = r_stall_cycles;

endmodule
